// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct codes,
// FSM states, ALU operations and the funct3-to-ALU mapping helper.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_e;

    // alt_sub turns ADD into SUB (register form only); alt_sra turns SRL into SRA
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3,
                                          input logic alt_sub,
                                          input logic alt_sra);
        case (f3)
            F3_ADD:  return alt_sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt_sra ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU. The lt/ltu flags each come from a single 33-bit
// subtract and are shared by SLT/SLTU and the branch comparator.
module core_alu
    import core_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    input  logic [4:0]  shamt,
    output logic [31:0] y,
    output logic        lt,
    output logic        ltu,
    output logic        eq
);

    logic signed [32:0] diff_s;
    logic        [32:0] diff_u;
    logic signed [31:0] a_s;

    // Compare flags and result select
    always_comb begin
        a_s    = a;
        diff_s = {a[31], a} - {b[31], b};
        diff_u = {1'b0, a} - {1'b0, b};
        lt     = diff_s[32];
        ltu    = diff_u[32];
        eq     = (a == b);
        y      = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = diff_u[31:0];
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {31'd0, lt};
            ALU_SLTU:  y = {31'd0, ltu};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = a_s >>> shamt;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32I/RV32E core: FETCH/DECODE/EXECUTE/WRITEBACK with a sticky
// HALT on illegal encodings. Define CORE_BRANCH_EN to make BRANCH/JAL/JALR
// legal; otherwise those opcodes halt and next_pc is always pc+4.
module mc_core
    import core_pkg::*;
#(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        retire,
    output logic        halted,
    output logic [31:0] pc_o
);

    localparam int AW = (NREGS == 16) ? 4 : 5;

    if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
        $error("mc_core: NREGS must be 32 or 16");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("mc_core: RESET_PC must be 4-byte aligned");
    end

    function automatic logic idx_ok(input logic [4:0] idx);
        return (NREGS == 32) || (idx[4] == 1'b0);
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction
    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'd0};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    state_e      state;
    logic [31:0] pc;
    logic [31:0] rf [NREGS];

    // fetch -> decode
    logic [31:0] instr_p0;
    // decode -> execute
    logic [31:0] rs1_p1, rs2_p1, imm_p1;
    alu_op_e     aluop_p1;
    logic        use_pc_p1, use_imm_p1, wen_p1, br_p1, jal_p1, jalr_p1;
    logic [AW-1:0] rd_p1;
    logic [2:0]  f3_p1;
    // execute -> writeback
    logic [31:0] res_p2, npc_p2;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_val, rs2_val, dec_imm;
    alu_op_e     dec_aluop;
    logic        dec_illegal, dec_use_pc, dec_use_imm, dec_wen;
    logic        dec_br, dec_jal, dec_jalr;

    logic [31:0] alu_a, alu_b, alu_y, pc_plus4, br_target, exe_npc, exe_res;
    logic        alu_lt, alu_ltu, alu_eq, br_take, exe_misalign;

    assign pc_o    = pc;
    assign opc     = instr_p0[6:0];
    assign rd_idx  = instr_p0[11:7];
    assign f3      = instr_p0[14:12];
    assign rs1_idx = instr_p0[19:15];
    assign rs2_idx = instr_p0[24:20];
    assign f7      = instr_p0[31:25];
    assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf[instr_p0[15 +: AW]];
    assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf[instr_p0[20 +: AW]];

    // Decoder: classify the latched instruction and pick operands/immediate
    always_comb begin
        dec_illegal = 1'b1;
        dec_aluop   = ALU_ADD;
        dec_use_pc  = 1'b0;
        dec_use_imm = 1'b0;
        dec_wen     = 1'b0;
        dec_imm     = imm_i(instr_p0);
        dec_br      = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_illegal = !idx_ok(rd_idx);
                dec_aluop   = ALU_PASSB;
                dec_use_imm = 1'b1;
                dec_wen     = 1'b1;
                dec_imm     = imm_u(instr_p0);
            end
            OPC_AUIPC: begin
                dec_illegal = !idx_ok(rd_idx);
                dec_use_pc  = 1'b1;
                dec_use_imm = 1'b1;
                dec_wen     = 1'b1;
                dec_imm     = imm_u(instr_p0);
            end
            OPC_OPIMM: begin
                dec_illegal = !idx_ok(rd_idx) || !idx_ok(rs1_idx) ||
                              (f3 == F3_SLL && f7 != F7_BASE) ||
                              (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
                dec_aluop   = f3_to_alu(f3, 1'b0, instr_p0[30]);
                dec_use_imm = 1'b1;
                dec_wen     = 1'b1;
            end
            OPC_OP: begin
                dec_illegal = !idx_ok(rd_idx) || !idx_ok(rs1_idx) || !idx_ok(rs2_idx) ||
                              !(f7 == F7_BASE ||
                                (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
                dec_aluop   = f3_to_alu(f3, instr_p0[30], instr_p0[30]);
                dec_wen     = 1'b1;
            end
`ifdef CORE_BRANCH_EN
            OPC_BRANCH: begin
                dec_illegal = !idx_ok(rs1_idx) || !idx_ok(rs2_idx) ||
                              f3 == 3'b010 || f3 == 3'b011;
                dec_aluop   = ALU_SUB;
                dec_imm     = imm_b(instr_p0);
                dec_br      = 1'b1;
            end
            OPC_JAL: begin
                dec_illegal = !idx_ok(rd_idx);
                dec_imm     = imm_j(instr_p0);
                dec_wen     = 1'b1;
                dec_jal     = 1'b1;
            end
            OPC_JALR: begin
                dec_illegal = !idx_ok(rd_idx) || !idx_ok(rs1_idx) || f3 != 3'b000;
                dec_use_imm = 1'b1;
                dec_wen     = 1'b1;
                dec_jalr    = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
    end

    assign alu_a = use_pc_p1 ? pc : rs1_p1;
    assign alu_b = use_imm_p1 ? imm_p1 : rs2_p1;

    core_alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .op    (aluop_p1),
        .shamt (alu_b[4:0]),
        .y     (alu_y),
        .lt    (alu_lt),
        .ltu   (alu_ltu),
        .eq    (alu_eq)
    );

    // Branch condition from the shared ALU compare flags
    always_comb begin
        case (f3_p1)
            F3_BEQ:  br_take = alu_eq;
            F3_BNE:  br_take = !alu_eq;
            F3_BLT:  br_take = alu_lt;
            F3_BGE:  br_take = !alu_lt;
            F3_BLTU: br_take = alu_ltu;
            F3_BGEU: br_take = !alu_ltu;
            default: br_take = 1'b0;
        endcase
    end

    // Next PC and writeback value; a target with bit 1 set is a halt
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_target = pc + imm_p1;
        exe_npc   = pc_plus4;
        if (jal_p1)
            exe_npc = br_target;
        else if (jalr_p1)
            exe_npc = {alu_y[31:1], 1'b0};
        else if (br_p1 && br_take)
            exe_npc = br_target;
        exe_res      = (jal_p1 || jalr_p1) ? pc_plus4 : alu_y;
        exe_misalign = exe_npc[1];
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b1;
            imem_addr <= RESET_PC;
            retire    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state     <= ST_DECODE;
                        imem_req  <= 1'b0;
                        imem_addr <= '0;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (exe_misalign) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= ST_WRITEBACK;
                        retire <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    state     <= ST_FETCH;
                    retire    <= 1'b0;
                    pc        <= npc_p2;
                    imem_req  <= 1'b1;
                    imem_addr <= npc_p2;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    // Datapath stage registers, loaded in the state that produces them
    always_ff @(posedge clk) begin
        // fetch -> decode
        if (state == ST_FETCH && imem_ready)
            instr_p0 <= imem_rdata;
        // decode -> execute
        if (state == ST_DECODE) begin
            rs1_p1     <= rs1_val;
            rs2_p1     <= rs2_val;
            imm_p1     <= dec_imm;
            aluop_p1   <= dec_aluop;
            use_pc_p1  <= dec_use_pc;
            use_imm_p1 <= dec_use_imm;
            wen_p1     <= dec_wen;
            rd_p1      <= instr_p0[7 +: AW];
            f3_p1      <= f3;
            br_p1      <= dec_br;
            jal_p1     <= dec_jal;
            jalr_p1    <= dec_jalr;
        end
        // execute -> writeback
        if (state == ST_EXECUTE) begin
            res_p2 <= exe_res;
            npc_p2 <= exe_npc;
        end
    end

    // Register file write; x0 is never written and reset cancels the write
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_WRITEBACK && wen_p1 && rd_p1 != '0)
            rf[rd_p1] <= res_p2;
    end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: table of small programs with expected register
// values, plus hand-written sequences for reset, wait states and halts.
module tb_mc_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic        imem_req, imem_req16;
    logic [31:0] imem_addr, imem_addr16;
    logic [31:0] imem_rdata, imem_rdata16;
    logic        retire, retire16, halted, halted16;
    logic [31:0] pc_o, pc16;

    always #5 clk = ~clk;

    mc_core #(.NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .retire(retire), .halted(halted), .pc_o(pc_o)
    );

    mc_core #(.NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req16), .imem_addr(imem_addr16),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata16),
        .retire(retire16), .halted(halted16), .pc_o(pc16)
    );

    logic [31:0] mem [64];

    always_comb begin
        imem_rdata = 32'h0;
        if (imem_addr[31:8] == 24'd0 && imem_addr[1:0] == 2'b00)
            imem_rdata = mem[imem_addr[7:2]];
    end

    always_comb begin
        imem_rdata16 = 32'h0;
        if (imem_addr16[31:8] == 24'd0 && imem_addr16[1:0] == 2'b00)
            imem_rdata16 = mem[imem_addr16[7:2]];
    end

    typedef struct {
        string       name;
        int          pid;
        int          rd;
        logic [31:0] exp;
    } vec_t;

    logic [31:0] progs [5][8];
    int          plen [5];
    vec_t        vecs [$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [63:0] ret_mask, ret16_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic load_prog(input int pid);
        clear_mem();
        for (int i = 0; i < plen[pid]; i++) mem[i] = progs[pid][i];
    endtask

    // record retire pulses for the current cycle, then advance one cycle
    task automatic tick();
        if (cyc < 64) begin
            if (retire === 1'b1)   ret_mask[cyc]   = 1'b1;
            if (retire16 === 1'b1) ret16_mask[cyc] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // leaves the bench in cycle 1, the first cycle after reset
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        cyc        = 1;
        ret_mask   = '0;
        ret16_mask = '0;
    endtask

    task automatic run(input int ncyc, input int stall);
        for (int k = 0; k < ncyc; k++) begin
            imem_ready = (cyc > stall);
            tick();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b1;

        // ADDI x1,x0,5 ; ADDI x2,x0,-3 ; ADD x3,x1,x2
        progs[0] = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 0, 0, 0, 0, 0};
        plen[0]  = 3;
        // LUI x1,0x80000 ; SRAI x2,x1,4 ; SRLI x3,x1,4 ; SLT x4,x1,x0 ; SLTU x5,x1,x0
        progs[1] = '{32'h800000B7, 32'h4040D113, 32'h0040D193, 32'h0000A233, 32'h0000B2B3, 0, 0, 0};
        plen[1]  = 5;
        // ADDI x1,x0,0x55 ; XORI x2 ; ORI x3 ; ANDI x4 (0xF0) ; SLLI x5,4 ; SLTI x6,-1 ; SLTIU x7,-1 ; SUB x8,x0,x1
        progs[2] = '{32'h05500093, 32'h0F00C113, 32'h0F00E193, 32'h0F00F213,
                     32'h00409293, 32'hFFF0A313, 32'hFFF0B393, 32'h40100433};
        plen[2]  = 8;
        // ADDI x0,x0,7 ; ADD x6,x0,x0 ; AUIPC x9,0x12345 (at pc 8)
        progs[3] = '{32'h00700013, 32'h00000333, 32'h12345497, 0, 0, 0, 0, 0};
        plen[3]  = 3;
        // ADDI x1,x0,-8 ; ADDI x2,x0,2 ; SRA x3 ; SRL x4 ; SLL x5 ; SLT x6 ; SLTU x7 ; XOR x8
        progs[4] = '{32'hFF800093, 32'h00200113, 32'h4020D1B3, 32'h0020D233,
                     32'h002092B3, 32'h0020A333, 32'h0020B3B3, 32'h0020C433};
        plen[4]  = 8;

        vecs.push_back('{"addi_x1",   0, 1, 32'd5});
        vecs.push_back('{"addi_neg",  0, 2, 32'hFFFF_FFFD});
        vecs.push_back('{"add_x3",    0, 3, 32'd2});
        vecs.push_back('{"lui",       1, 1, 32'h8000_0000});
        vecs.push_back('{"srai",      1, 2, 32'hF800_0000});
        vecs.push_back('{"srli",      1, 3, 32'h0800_0000});
        vecs.push_back('{"slt_neg",   1, 4, 32'd1});
        vecs.push_back('{"sltu_big",  1, 5, 32'd0});
        vecs.push_back('{"xori",      2, 2, 32'h0000_00A5});
        vecs.push_back('{"ori",       2, 3, 32'h0000_00F5});
        vecs.push_back('{"andi",      2, 4, 32'h0000_0050});
        vecs.push_back('{"slli",      2, 5, 32'h0000_0550});
        vecs.push_back('{"slti",      2, 6, 32'd0});
        vecs.push_back('{"sltiu",     2, 7, 32'd1});
        vecs.push_back('{"sub",       2, 8, 32'hFFFF_FFAB});
        vecs.push_back('{"x0_hard",   3, 6, 32'd0});
        vecs.push_back('{"auipc",     3, 9, 32'h1234_5008});
        vecs.push_back('{"sra_reg",   4, 3, 32'hFFFF_FFFE});
        vecs.push_back('{"srl_reg",   4, 4, 32'h3FFF_FFFE});
        vecs.push_back('{"sll_reg",   4, 5, 32'hFFFF_FFE0});
        vecs.push_back('{"slt_reg",   4, 6, 32'd1});
        vecs.push_back('{"sltu_reg",  4, 7, 32'd0});
        vecs.push_back('{"xor_reg",   4, 8, 32'hFFFF_FFFA});

        @(posedge clk);
        #1;

        // table-driven register results on both the RV32I and RV32E builds
        foreach (vecs[v]) begin
            load_prog(vecs[v].pid);
            do_reset();
            run(4 * plen[vecs[v].pid], 0);
            check({vecs[v].name, "_r32"}, {32'h0, dut.rf[vecs[v].rd]},   {32'h0, vecs[v].exp});
            check({vecs[v].name, "_r16"}, {32'h0, dut16.rf[vecs[v].rd]}, {32'h0, vecs[v].exp});
        end

        // reset state and retire cadence with ready tied high
        load_prog(0);
        do_reset();
        check("rst_req",    {63'h0, imem_req}, 64'd1);
        check("rst_addr",   {32'h0, imem_addr}, 64'd0);
        check("rst_retire", {63'h0, retire}, 64'd0);
        check("rst_halted", {63'h0, halted}, 64'd0);
        check("rst_pc",     {32'h0, pc_o}, 64'd0);
        run(12, 0);
        check("retire_cadence", ret_mask, 64'h1110);
        check("pc_after3",      {32'h0, pc_o}, 64'd12);

        // first fetch stalled for 3 cycles: request held stable
        load_prog(0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            imem_ready = (cyc > 3);
            check($sformatf("stall_hold_c%0d", cyc), {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
            tick();
        end
        run(8, 0);
        check("stall_retire", ret_mask, 64'h880);

        // all-zero word is illegal: halt after decode, no retire, no request
        clear_mem();
        do_reset();
        run(2, 0);
        check("zero_halt_c3", {62'h0, halted, imem_req}, 64'd2);
        run(10, 0);
        check("zero_halt_sticky", {61'h0, halted, imem_req, retire}, 64'd4);
        check("zero_no_retire",   ret_mask, 64'd0);
        check("zero_pc",          {32'h0, pc_o}, 64'd0);

        // register index beyond NREGS halts only the 16-register build
        clear_mem();
        mem[0] = 32'h00208833;  // ADD x16,x1,x2
        do_reset();
        run(2, 0);
        check("rv32e_halt", {62'h0, halted16, halted}, 64'd2);
        run(2, 0);
        check("rv32e_no_retire", ret16_mask, 64'd0);
        check("rv32i_retire",    ret_mask, 64'h10);

`ifdef CORE_BRANCH_EN
        clear_mem();
        mem[0] = 32'h00000463;  // BEQ x0,x0,+8
        do_reset();
        run(4, 0);
        check("beq_taken", {32'h0, pc_o}, 64'h8);

        clear_mem();
        mem[0] = 32'h00001463;  // BNE x0,x0,+8
        do_reset();
        run(4, 0);
        check("bne_not_taken", {32'h0, pc_o}, 64'h4);

        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 32'h00000013;
        mem[4] = 32'h00C000EF;  // JAL x1,+12 at pc 0x10
        do_reset();
        run(20, 0);
        check("jal_pc",   {32'h0, pc_o}, 64'h1C);
        check("jal_link", {32'h0, dut.rf[1]}, 64'h14);

        clear_mem();
        mem[0] = 32'h00600093;  // ADDI x1,x0,6
        mem[1] = 32'h00008067;  // JALR x0,0(x1) -> target 6, misaligned
        do_reset();
        run(10, 0);
        check("jalr_misalign_halt",   {63'h0, halted}, 64'd1);
        check("jalr_misalign_retire", ret_mask, 64'h10);
`else
        clear_mem();
        mem[0] = 32'h00000463;  // BEQ x0,x0,+8 is illegal in this build
        do_reset();
        run(2, 0);
        check("beq_illegal_halt", {63'h0, halted}, 64'd1);
        run(6, 0);
        check("beq_no_retire", ret_mask, 64'd0);
        check("beq_pc",        {32'h0, pc_o}, 64'd0);
`endif

        // reset during DECODE of the second ADDI discards it
        clear_mem();
        mem[0] = 32'h00900093;  // ADDI x1,x0,9
        mem[1] = 32'h00500093;  // ADDI x1,x0,5
        do_reset();
        run(5, 0);
        rst_n = 1'b0;
        tick();
        check("rst_dec_req",    {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
        check("rst_dec_pc",     {32'h0, pc_o}, 64'd0);
        check("rst_dec_retire", {63'h0, retire}, 64'd0);
        repeat (4) tick();
        check("rst_dec_retires", ret_mask, 64'h10);
        check("rst_dec_no_wr",   {32'h0, dut.rf[1]}, 64'd9);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
